seg_display: RTL

- Drives the board's 3-digit multiplexed 7-segment display from the 12-bit status code produced by the status-combining stage.
- Time-multiplexes the three hex nibbles onto one shared segment bus with per-digit anode enables.
- Inserts a blanking gap between digits to prevent ghosting.
- Latches the input once per frame so a digit value never changes mid-scan.

---
 rtl/seg_display_pkg.sv | 49 ++++
 rtl/seg_display_hex_to_seg.sv | 41 ++++
 rtl/seg_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_pkg
//
// Shared definitions for the multiplexed 7-segment display driver.
//   - SEG_HEX_0 .. SEG_HEX_F : logical (active-high) segment patterns,
//                              bit order g..a (bit6 = g, bit0 = a)
//   - SEG_BLANK              : all segments off (logical)
//   - ST_BLANK / ST_SHOW     : scan FSM state encodings
//   - anodeOneHot()          : digit index -> logical one-hot anode enable
// ---------------------------------------------------------------------------
package seg_display_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan FSM states: all anodes dark, or one digit lit
    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    // Logical anode enable for a digit index; index 3 never occurs and
    // maps to all-off so an illegal index can never light two digits
    function automatic logic [2:0] anodeOneHot(input logic [1:0] idx);
        logic [2:0] an;
        case (idx)
            2'd0:    an = 3'b001;
            2'd1:    an = 3'b010;
            2'd2:    an = 3'b100;
            default: an = 3'b000;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_display_hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
//
// Purely combinational hex nibble to 7-segment decoder. Output is the
// logical pattern (1 = segment lit); board polarity is applied by the
// caller.
//   nibble_i [3:0] : hex value to display
//   seg_o    [6:0] : logical segments, bit0 = a ... bit6 = g
// ---------------------------------------------------------------------------
module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Full 16-entry table; every nibble value is a legal hex digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display.sv
// ---------------------------------------------------------------------------
// seg_display
//
// Drives a 3-digit multiplexed 7-segment display from a 12-bit status code.
// Each digit slot is BLANK_CYCLES of all-anodes-off followed by
// DIGIT_CYCLES with one anode lit. The input is captured once per frame so
// a digit never changes mid-scan. All outputs are registered.
//
// Parameters:
//   DIGIT_CYCLES : cycles a digit is lit per slot (>= 1)
//   BLANK_CYCLES : cycles all anodes are dark before each digit (>= 1)
//   ACTIVE_LOW   : 1 = segment/dp/anode outputs are active-low
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   digits      : [3:0] digit 0 (rightmost) ... [11:8] digit 2 (leftmost)
//   dp_mask     : decimal point enable, bit i = digit i
//   enable      : 1 = scan, 0 = display dark and scan restarted
//   seg_out     : segments, bit0 = a ... bit6 = g
//   dp_out      : decimal point
//   an_out      : anode enables, bit i = digit i
//   frame_tick  : one-cycle pulse at the end of each complete frame
// ---------------------------------------------------------------------------
module seg_display
    import seg_display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] digits,
    input  logic [2:0]  dp_mask,
    input  logic        enable,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [2:0]  an_out,
    output logic        frame_tick
);

    localparam int MAX_CYCLES = (BLANK_CYCLES > DIGIT_CYCLES) ? BLANK_CYCLES : DIGIT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    // Polarity masks: the logical value is XORed with these on the way out,
    // so "off" is all-ones on an active-low board
    localparam logic       POL    = (ACTIVE_LOW != 0);
    localparam logic [6:0] POL7   = {7{POL}};
    localparam logic [2:0] POL3   = {3{POL}};
    localparam logic [6:0] SEG_OFF = SEG_BLANK ^ POL7;
    localparam logic [2:0] AN_OFF  = 3'b000 ^ POL3;

    logic             state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      snapDigits_q;
    logic [2:0]       snapDp_q;
    logic             restart_q;
    logic             frameWrap;
    logic             snapTake;

    logic [3:0]       curNibble;
    logic             curDp;
    logic [6:0]       curSeg;

    logic [6:0]       segOut_q, segOut_d;
    logic             dpOut_q, dpOut_d;
    logic [2:0]       anOut_q, anOut_d;
    logic             frameTick_q;

    // Next-state logic. Disabling the display parks the scan at the start
    // of a frame so re-enabling always begins with a blank gap on digit 0.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + CNT_W'(1);
        frameWrap = 1'b0;
        if (!enable) begin
            state_d = ST_BLANK;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == DIGIT_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                if (idx_q == 2'd2) begin
                    idx_d     = 2'd0;
                    frameWrap = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    // The snapshot is refreshed only at frame boundaries, or on the first
    // enabled cycle after reset / after the display was disabled
    assign snapTake = enable && (restart_q || frameWrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            snapDigits_q <= 12'h000;
            snapDp_q     <= 3'b000;
            restart_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            restart_q <= !enable;
            if (snapTake) begin
                snapDigits_q <= digits;
                snapDp_q     <= dp_mask;
            end
        end
    end

    // Select the captured nibble and decimal point for the current digit
    always_comb begin
        curNibble = snapDigits_q[3:0];
        curDp     = snapDp_q[0];
        case (idx_q)
            2'd1: begin
                curNibble = snapDigits_q[7:4];
                curDp     = snapDp_q[1];
            end
            2'd2: begin
                curNibble = snapDigits_q[11:8];
                curDp     = snapDp_q[2];
            end
            default: begin
                curNibble = snapDigits_q[3:0];
                curDp     = snapDp_q[0];
            end
        endcase
    end

    hex_to_seg u_hexToSeg (
        .nibble_i (curNibble),
        .seg_o    (curSeg)
    );

    // Output values for the next cycle. Outputs follow the registered
    // state, so they lag a state change by one clock; dropping enable
    // darkens the display on the very next edge.
    always_comb begin
        segOut_d = SEG_OFF;
        dpOut_d  = POL;
        anOut_d  = AN_OFF;
        if (enable && (state_q == ST_SHOW)) begin
            segOut_d = curSeg ^ POL7;
            dpOut_d  = curDp ^ POL;
            anOut_d  = anodeOneHot(idx_q) ^ POL3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segOut_q    <= SEG_OFF;
            dpOut_q     <= POL;
            anOut_q     <= AN_OFF;
            frameTick_q <= 1'b0;
        end else begin
            segOut_q    <= segOut_d;
            dpOut_q     <= dpOut_d;
            anOut_q     <= anOut_d;
            frameTick_q <= frameWrap;
        end
    end

    assign seg_out    = segOut_q;
    assign dp_out     = dpOut_q;
    assign an_out     = anOut_q;
    assign frame_tick = frameTick_q;

endmodule
